// File: rtl/recirc_demux_buffered.sv
// Registered recirculation demux: forwards words to the striping demux while active,
// otherwise loops them back and holds them in a FIFO for in-order replay.
module recirc_demux_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  valid_in,
  input  logic                  active,
  output logic [DATA_WIDTH-1:0] out_demux,
  output logic                  valid_demux,
  output logic [DATA_WIDTH-1:0] out_block,
  output logic                  valid_block,
  output logic [CNT_WIDTH-1:0]  recirc_count,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic                  fifo_full_reg, overflow_reg;
  logic [DATA_WIDTH-1:0] out_demux_reg, out_demux_next;
  logic [DATA_WIDTH-1:0] out_block_reg, out_block_next;
  logic                  valid_demux_reg, valid_demux_next;
  logic                  valid_block_reg, valid_block_next;
  logic                  push, pop, drop;
  logic                  fifo_empty, fifo_at_full;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_at_full = (count_reg == CNT_WIDTH'(DEPTH));

  always_comb begin
    out_demux_next   = '0;
    valid_demux_next = 1'b0;
    out_block_next   = '0;
    valid_block_next = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    drop             = 1'b0;
    if (!active) begin
      // Loop-back always shows the word, even when the FIFO has no room for it.
      valid_block_next = valid_in;
      out_block_next   = valid_in ? din : '0;
      push             = valid_in && !fifo_at_full;
      drop             = valid_in && fifo_at_full;
    end else if (fifo_empty) begin
      valid_demux_next = valid_in;
      out_demux_next   = valid_in ? din : '0;
    end else begin
      // Replay the head; new input queues behind it, so a full FIFO still accepts it.
      pop              = 1'b1;
      push             = valid_in;
      valid_demux_next = 1'b1;
      out_demux_next   = mem[rd_ptr_reg];
    end
    count_next = count_reg + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      fifo_full_reg   <= 1'b0;
      overflow_reg    <= 1'b0;
      out_demux_reg   <= '0;
      valid_demux_reg <= 1'b0;
      out_block_reg   <= '0;
      valid_block_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg       <= count_next;
      fifo_full_reg   <= (count_next == CNT_WIDTH'(DEPTH));
      overflow_reg    <= overflow_reg | drop;
      out_demux_reg   <= out_demux_next;
      valid_demux_reg <= valid_demux_next;
      out_block_reg   <= out_block_next;
      valid_block_reg <= valid_block_next;
    end
  end

  assign out_demux    = out_demux_reg;
  assign valid_demux  = valid_demux_reg;
  assign out_block    = out_block_reg;
  assign valid_block  = valid_block_reg;
  assign recirc_count = count_reg;
  assign fifo_full    = fifo_full_reg;
  assign overflow     = overflow_reg;

endmodule
